// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the icache/dcache memory arbiter.
// Imported by the arbiter top and its round-robin selector.
package mem_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 64;
    localparam int DEF_LINE_WIDTH = 512;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    typedef enum logic {
        ICACHE,
        DCACHE
    } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector between icache and dcache.
// On a tie the requester that was not granted last wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       req_icache,
    input  logic       req_dcache,
    input  owner_t     last_grant,
    output logic [1:0] grant
);

    // one-hot grant: bit 0 icache, bit 1 dcache
    always_comb begin
        grant = 2'b00;
        if (req_icache && (!req_dcache || last_grant == DCACHE)) begin
            grant = 2'b01;
        end else if (req_dcache) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache line reads and dcache reads/write-backs onto a
// single memory-controller port, one transaction at a time.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int LINE_WIDTH     = DEF_LINE_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_rvalid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_rvalid,
    output logic                  err,
    output logic                  i_inval,
    output logic                  d_inval,
    output logic [ADDR_WIDTH-1:0] mc_addr,
    output logic [LINE_WIDTH-1:0] mc_wdata,
    output logic                  mc_start_req,
    output logic                  mc_wr_en,
    input  logic [LINE_WIDTH-1:0] mc_rdata,
    input  logic                  mc_data_valid,
    input  logic                  mc_invalidate
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t                state;
    state_t                state_nxt;
    owner_t                owner;
    owner_t                last_grant;
    logic [1:0]            grant;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [LINE_WIDTH-1:0] lat_wdata;
    logic                  lat_we;
    logic [CW-1:0]         wait_cnt;
    logic                  tmo_flag;
    logic                  tmo_hit;

    rr_arb2 u_rr (
        .req_icache (i_req),
        .req_dcache (d_req),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // data_valid on the last allowed cycle still counts as a completion
    assign tmo_hit = (wait_cnt == TMO_LAST) && !mc_data_valid;

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (|grant) state_nxt = BUSY;
            BUSY: if (mc_data_valid || tmo_hit) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // outputs decoded from the current state
    always_comb begin
        mc_start_req = 1'b0;
        mc_addr      = '0;
        mc_wdata     = '0;
        mc_wr_en     = 1'b0;
        i_rvalid     = 1'b0;
        d_rvalid     = 1'b0;
        err          = 1'b0;
        unique case (state)
            BUSY: begin
                mc_start_req = 1'b1;
                mc_addr      = lat_addr;
                mc_wdata     = lat_wdata;
                mc_wr_en     = lat_we;
            end
            RESP: begin
                i_rvalid = (owner == ICACHE);
                d_rvalid = (owner == DCACHE);
                err      = tmo_flag;
            end
            default: ;
        endcase
    end

    // latch the winning request so later req changes cannot disturb it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner     <= ICACHE;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
        end else if (state == IDLE && |grant) begin
            owner     <= grant[1] ? DCACHE : ICACHE;
            lat_addr  <= grant[1] ? d_addr : i_addr;
            lat_wdata <= grant[1] ? d_wdata : '0;
            lat_we    <= grant[1] & d_we;
        end
    end

    // round-robin history moves only when a transaction completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= DCACHE;
        end else if (state == BUSY && state_nxt == RESP) begin
            last_grant <= owner;
        end
    end

    // BUSY wait counter and timeout flag carried into RESP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            tmo_flag <= 1'b0;
        end else if (state == BUSY) begin
            wait_cnt <= wait_cnt + 1'b1;
            tmo_flag <= tmo_hit;
        end else if (state == IDLE) begin
            wait_cnt <= '0;
            tmo_flag <= 1'b0;
        end
    end

    // read data capture; write-backs and timeouts leave rdata alone
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_rdata <= '0;
            d_rdata <= '0;
        end else if (state == BUSY && mc_data_valid && !lat_we) begin
            if (owner == ICACHE) begin
                i_rdata <= mc_rdata;
            end else begin
                d_rdata <= mc_rdata;
            end
        end
    end

    // invalidate is forwarded to both caches regardless of FSM state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_inval <= 1'b0;
            d_inval <= 1'b0;
        end else begin
            i_inval <= mc_invalidate;
            d_inval <= mc_invalidate;
        end
    end

endmodule
